// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - ALU/MD op encodings, forwarding error marker and MD state type
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;
  localparam logic [3:0] ALU_SRLV = 4'd12;
  localparam logic [3:0] ALU_SRAV = 4'd13;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  // Driven onto an operand when the forwarding select points past the last source.
  localparam logic [31:0] FWD_ERR = 32'h1234_ABCD;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/ex_md_stage_md_unit.sv
// rtl/ex_md_stage_md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Optional madd/maddu/msub/msubu support under EX_MADD_EN.
module md_unit
  import ex_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_i,
  input  logic [3:0]        md_op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int W2    = 2 * DATA_W;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic              is_mul, is_div, start;
  logic [W2-1:0]     prod_s, prod_u;
  logic [DATA_W-1:0] quot_s, rem_s, quot_u, rem_u;

`ifdef EX_MADD_EN
  assign is_mul = md_op_i inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
  assign is_mul = md_op_i inside {MD_MULT, MD_MULTU};
`endif
  assign is_div = md_op_i inside {MD_DIV, MD_DIVU};
  assign start  = issue_i && (state_q == MD_IDLE) && (is_mul || is_div);
  assign busy_o = (state_q == MD_BUSY) || start;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  // Arithmetic works on the latched operands; only sampled on the final BUSY cycle.
  assign prod_s = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
  assign prod_u = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
  assign quot_s = $signed(a_q) / $signed(b_q);
  assign rem_s  = $signed(a_q) % $signed(b_q);
  assign quot_u = a_q / b_q;
  assign rem_u  = a_q % b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          op_d    = md_op_i;
          a_d     = a_i;
          b_d     = b_i;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end else if (issue_i && (md_op_i == MD_MTHI)) begin
          hi_d = a_i;
        end else if (issue_i && (md_op_i == MD_MTLO)) begin
          lo_d = a_i;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          case (op_q)
            MD_MULT:  {hi_d, lo_d} = prod_s;
            MD_MULTU: {hi_d, lo_d} = prod_u;
            MD_DIV: begin
              if (b_q != '0) begin
                lo_d = quot_s;
                hi_d = rem_s;
              end
            end
            MD_DIVU: begin
              if (b_q != '0) begin
                lo_d = quot_u;
                hi_d = rem_u;
              end
            end
`ifdef EX_MADD_EN
            MD_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            MD_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
            MD_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            MD_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
            default: begin
            end
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: rtl/ex_md_stage.sv
// rtl/ex_md_stage.sv - execute stage: operand forwarding, ALU, MD unit, EX/Mem register
// Optional feature macro: EX_MADD_EN (multiply-accumulate ops inside md_unit).
module ex_md_stage
  import ex_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int NUM_FWD     = 2,
  parameter int T_W         = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(32'h0000_3000)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 pc_in,
  input  logic [REG_AW-1:0]                 waddr_in,
  input  logic [T_W-1:0]                    tnew_in,
  input  logic [DATA_W-1:0]                 rdata0,
  input  logic [DATA_W-1:0]                 rdata1,
  input  logic [DATA_W-1:0]                 imm32,
  input  logic [4:0]                        shamt,
  input  logic [3:0]                        alu_op,
  input  logic                              alu_src_imm,
  input  logic [3:0]                        md_op,
  input  logic [DATA_W-1:0]                 id_res,
  input  logic                              use_id_res,
  input  logic [NUM_FWD*DATA_W-1:0]         fwd_data,
  input  logic [$clog2(NUM_FWD+1)-1:0]      fwd_sel0,
  input  logic [$clog2(NUM_FWD+1)-1:0]      fwd_sel1,
  output logic                              md_busy,
  output logic [REG_AW-1:0]                 waddr_ex,
  output logic [T_W-1:0]                    tnew_ex,
  output logic                              valid_o,
  output logic [DATA_W-1:0]                 pc_o,
  output logic [DATA_W-1:0]                 alu_out_o,
  output logic [DATA_W-1:0]                 dm_wdata_o,
  output logic [REG_AW-1:0]                 waddr_o,
  output logic [T_W-1:0]                    tnew_o
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam logic [DATA_W-1:0] ERR_W = DATA_W'(FWD_ERR);

  function automatic logic [DATA_W-1:0] pick_src(
    input logic [SEL_W-1:0]          sel,
    input logic [DATA_W-1:0]         reg_val,
    input logic [NUM_FWD*DATA_W-1:0] srcs
  );
    logic [DATA_W-1:0] v;
    v = ERR_W;
    if (sel == '0) v = reg_val;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (sel == SEL_W'(k)) v = srcs[k*DATA_W-1 -: DATA_W];
    end
    return v;
  endfunction

  logic [DATA_W-1:0] op0, op1, in1, alu_res, result, hi, lo;
  logic [4:0]        vsh;
  logic              kill;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d, alu_out_q, alu_out_d, wdata_q, wdata_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [T_W-1:0]    tnew_q, tnew_d;

  assign op0 = pick_src(fwd_sel0, rdata0, fwd_data);
  assign op1 = pick_src(fwd_sel1, rdata1, fwd_data);
  assign in1 = alu_src_imm ? imm32 : op1;
  assign vsh = op0[4:0];

  // Shifts move In1; the amount is shamt (fixed) or op0[4:0] (variable).
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = op0 + in1;
      ALU_SUB:  alu_res = op0 - in1;
      ALU_AND:  alu_res = op0 & in1;
      ALU_OR:   alu_res = op0 | in1;
      ALU_XOR:  alu_res = op0 ^ in1;
      ALU_NOR:  alu_res = ~(op0 | in1);
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op0) < $signed(in1))};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op0 < in1)};
      ALU_SLL:  alu_res = in1 << shamt;
      ALU_SRL:  alu_res = in1 >> shamt;
      ALU_SRA:  alu_res = $signed(in1) >>> shamt;
      ALU_SLLV: alu_res = in1 << vsh;
      ALU_SRLV: alu_res = in1 >> vsh;
      ALU_SRAV: alu_res = $signed(in1) >>> vsh;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    result = alu_res;
    if (use_id_res)             result = id_res;
    else if (md_op == MD_MFHI)  result = hi;
    else if (md_op == MD_MFLO)  result = lo;
  end

  md_unit #(
    .DATA_W      (DATA_W),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk     (clk),
    .reset   (reset),
    .issue_i (in_valid && !flush),
    .md_op_i (md_op),
    .a_i     (op0),
    .b_i     (op1),
    .busy_o  (md_busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  assign waddr_ex = waddr_in;
  assign tnew_ex  = (tnew_in != '0) ? tnew_in - 1'b1 : '0;

  // Bubbles clear only the fields the hazard logic looks at; data fields load regardless.
  assign kill      = flush || !in_valid;
  assign valid_d   = !kill;
  assign pc_d      = pc_in;
  assign alu_out_d = result;
  assign wdata_d   = op1;
  assign waddr_d   = kill ? '0 : waddr_in;
  assign tnew_d    = kill ? '0 : tnew_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      alu_out_q <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      tnew_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      alu_out_q <= alu_out_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      tnew_q    <= tnew_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign alu_out_o  = alu_out_q;
  assign dm_wdata_o = wdata_q;
  assign waddr_o    = waddr_q;
  assign tnew_o     = tnew_q;

endmodule

// File: tb/tb_ex_md_stage.sv
// tb/tb_ex_md_stage.sv - self-checking bench for ex_md_stage
module tb_ex_md_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, alu_src_imm, use_id_res;
  logic [31:0] pc_in, rdata0, rdata1, imm32, id_res;
  logic [4:0]  waddr_in, shamt;
  logic [2:0]  tnew_in;
  logic [3:0]  alu_op, md_op;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_sel0, fwd_sel1;
  logic        md_busy, valid_o;
  logic [4:0]  waddr_ex, waddr_o;
  logic [2:0]  tnew_ex, tnew_o;
  logic [31:0] pc_o, alu_out_o, dm_wdata_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  ex_md_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .pc_in(pc_in),
    .waddr_in(waddr_in), .tnew_in(tnew_in), .rdata0(rdata0), .rdata1(rdata1),
    .imm32(imm32), .shamt(shamt), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .md_op(md_op), .id_res(id_res), .use_id_res(use_id_res), .fwd_data(fwd_data),
    .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .md_busy(md_busy), .waddr_ex(waddr_ex),
    .tnew_ex(tnew_ex), .valid_o(valid_o), .pc_o(pc_o), .alu_out_o(alu_out_o),
    .dm_wdata_o(dm_wdata_o), .waddr_o(waddr_o), .tnew_o(tnew_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; md_op = MD_NONE; use_id_res = 0; alu_src_imm = 0;
    alu_op = ALU_ADD; fwd_sel0 = 0; fwd_sel1 = 0; waddr_in = 0; tnew_in = 0; shamt = 0;
  endtask

  // Reference ALU in wide integer arithmetic: shifts as multiply/divide by powers of two.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] sh);
    longint p2, sy;
    logic [4:0] s;
    s = (op inside {ALU_SLLV, ALU_SRLV, ALU_SRAV}) ? x[4:0] : sh;
    p2 = longint'(1) << s;
    sy = longint'($signed(y));
    case (op)
      ALU_ADD:  return 32'(longint'(x) + longint'(y));
      ALU_SUB:  return 32'(longint'(x) - longint'(y));
      ALU_AND:  return x & y;
      ALU_OR:   return x | y;
      ALU_XOR:  return x ^ y;
      ALU_NOR:  return ~(x | y);
      ALU_SLT:  return (longint'($signed(x)) < sy) ? 32'd1 : 32'd0;
      ALU_SLTU: return (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
      ALU_SLL, ALU_SLLV: return 32'(longint'(y) * p2);
      ALU_SRL, ALU_SRLV: return 32'(longint'(y) / p2);
      ALU_SRA, ALU_SRAV: return 32'((sy >= 0) ? sy / p2 : (sy - p2 + 1) / p2);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_pick(input logic [1:0] sel, input logic [31:0] r,
                                           input logic [63:0] f);
    if (sel == 0) return r;
    if (sel == 1) return f[31:0];
    if (sel == 2) return f[63:32];
    return 32'h1234_ABCD;
  endfunction

  task automatic model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 0;
    case (op)
      MD_MULT:  begin p = sa * sb; {hi_m, lo_m} = p; lat = 5; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = p; lat = 5; end
      MD_DIV: begin
        lat = 10;
        if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      end
      MD_DIVU: begin
        lat = 10;
        if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      end
      default: lat = 0;
    endcase
  endtask

  task automatic read_hilo(input string tag);
    idle();
    in_valid = 1; md_op = MD_MFLO;
    tick();
    chk({tag, "_lo"}, alu_out_o, lo_m);
    md_op = MD_MFHI;
    tick();
    chk({tag, "_hi"}, alu_out_o, hi_m);
    idle();
  endtask

  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int lat, n;
    model_md(op, a, b, lat);
    idle();
    in_valid = 1; md_op = op; rdata0 = a; rdata1 = b;
    #1 chk({tag, "_busy_start"}, md_busy, 1);
    tick();
    idle();
    #1;
    n = 0;
    while (md_busy && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_latency"}, n, lat);
    read_hilo(tag);
  endtask

  initial begin
    int lat, n;
    logic [31:0] ra, rb, e0, e1, exp_res;
    logic [3:0]  rop;
    int t;

    tbl[0]  = '{ALU_ADD,  32'd5,          32'd7,          5'd0, 32'd12};
    tbl[1]  = '{ALU_SUB,  32'd3,          32'd5,          5'd0, 32'hFFFF_FFFE};
    tbl[2]  = '{ALU_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0, 32'hF000_F000};
    tbl[3]  = '{ALU_OR,   32'hF0F0_F0F0,  32'h0F0F_0F0F,  5'd0, 32'hFFFF_FFFF};
    tbl[4]  = '{ALU_XOR,  32'hFFFF_0000,  32'hFF00_FF00,  5'd0, 32'h00FF_FF00};
    tbl[5]  = '{ALU_NOR,  32'd0,          32'd0,          5'd0, 32'hFFFF_FFFF};
    tbl[6]  = '{ALU_SLT,  32'hFFFF_FFFF,  32'd1,          5'd0, 32'd1};
    tbl[7]  = '{ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          5'd0, 32'd0};
    tbl[8]  = '{ALU_SLL,  32'd9,          32'd1,          5'd4, 32'd16};
    tbl[9]  = '{ALU_SRL,  32'd0,          32'h8000_0000,  5'd4, 32'h0800_0000};
    tbl[10] = '{ALU_SRA,  32'd0,          32'h8000_0000,  5'd4, 32'hF800_0000};
    tbl[11] = '{ALU_SLLV, 32'd3,          32'd1,          5'd9, 32'd8};
    tbl[12] = '{ALU_SRLV, 32'd36,         32'h0000_0100,  5'd0, 32'h0000_0010};
    tbl[13] = '{ALU_SRAV, 32'd1,          32'hFFFF_FFFE,  5'd0, 32'hFFFF_FFFF};
    tbl[14] = '{ALU_ADD,  32'hFFFF_FFFF,  32'd2,          5'd0, 32'd1};

    idle();
    reset = 1; pc_in = 32'hAAAA_0000; rdata0 = 32'h55; rdata1 = 32'h66; imm32 = 0;
    id_res = 0; fwd_data = 0;
    tick();
    tick();
    chk("reset_md_busy", md_busy, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_pc", pc_o, 32'h0000_3000);
    chk("reset_alu_out", alu_out_o, 0);
    chk("reset_dm_wdata", dm_wdata_o, 0);
    chk("reset_waddr", waddr_o, 0);
    chk("reset_tnew", tnew_o, 0);
    reset = 0;
    hi_m = 0; lo_m = 0;
    read_hilo("reset_hilo");

    for (int i = 0; i < 15; i++) begin
      idle();
      in_valid = 1; alu_op = tbl[i].op; rdata0 = tbl[i].a; rdata1 = tbl[i].b;
      shamt = tbl[i].sh; pc_in = 32'h100 + 32'(i);
      tick();
      chk($sformatf("alu_tbl[%0d]", i), alu_out_o, tbl[i].exp);
      chk($sformatf("alu_tbl_wdata[%0d]", i), dm_wdata_o, tbl[i].b);
    end

    idle();
    in_valid = 1; rdata0 = 5; fwd_data = {32'd7, 32'h11}; fwd_sel0 = 2; fwd_sel1 = 1;
    alu_op = ALU_ADD; imm32 = 3; alu_src_imm = 1; rdata1 = 32'h99;
    tick();
    chk("fwd_src2_add_imm", alu_out_o, 32'd10);
    chk("fwd_wdata_not_imm", dm_wdata_o, 32'h11);
    fwd_sel0 = 3; alu_op = ALU_OR; imm32 = 0;
    tick();
    chk("fwd_err_marker", alu_out_o, 32'h1234_ABCD);

    run_md("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd4);
    run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_md("divu_zero", MD_DIVU, 32'd1234, 32'd0);

    idle();
    in_valid = 1; flush = 1; waddr_in = 8; tnew_in = 2; md_op = MD_MULT; rdata0 = 3; rdata1 = 3;
    #1 chk("flush_no_start", md_busy, 0);
    tick();
    chk("flush_valid", valid_o, 0);
    chk("flush_waddr", waddr_o, 0);
    chk("flush_tnew", tnew_o, 0);

    idle();
    in_valid = 1; md_op = MD_MTHI; rdata0 = 32'hCAFE_0001;
    tick();
    md_op = MD_MTLO; rdata0 = 32'hBEEF_0002;
    tick();
    flush = 1; md_op = MD_MTHI; rdata0 = 32'hDEAD_DEAD;
    tick();
    hi_m = 32'hCAFE_0001; lo_m = 32'hBEEF_0002;
    read_hilo("mthi_mtlo");

    idle();
    in_valid = 1; md_op = MD_MFHI; use_id_res = 1; id_res = 32'h0000_5A5A;
    tick();
    chk("id_res_priority", alu_out_o, 32'h0000_5A5A);

    idle();
    in_valid = 1; md_op = MD_MADD; rdata0 = 2; rdata1 = 3;
`ifdef EX_MADD_EN
    #1 chk("madd_start", md_busy, 1);
`else
    #1 chk("madd_is_none", md_busy, 0);
`endif
    idle();
    #1;

    model_md(MD_MULT, 32'd6, 32'd7, lat);
    in_valid = 1; md_op = MD_MULT; rdata0 = 6; rdata1 = 7;
    tick();
    idle();
    tick();
    in_valid = 1; flush = 1; waddr_in = 3;
    #1 chk("flush_busy_still", md_busy, 1);
    tick();
    idle();
    #1;
    n = 0;
    while (md_busy && n < 40) begin n++; tick(); end
    chk("flush_busy_remaining", n, lat - 2);
    read_hilo("flush_during_busy");

    idle();
    in_valid = 1; tnew_in = 0;
    #1 chk("tnew_ex_zero", tnew_ex, 0);
    tnew_in = 2; waddr_in = 5;
    #1 chk("tnew_ex_two", tnew_ex, 1);
    chk("waddr_ex", waddr_ex, 5);
    tick();
    chk("tnew_o_two", tnew_o, 1);
    chk("waddr_o", waddr_o, 5);
    chk("valid_o", valid_o, 1);

    for (int i = 0; i < 150; i++) begin
      idle();
      in_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      pc_in = $urandom; waddr_in = 5'($urandom); tnew_in = 3'($urandom);
      rdata0 = $urandom; rdata1 = $urandom; imm32 = $urandom;
      fwd_data = {$urandom, $urandom};
      fwd_sel0 = 2'($urandom_range(0, 3)); fwd_sel1 = 2'($urandom_range(0, 3));
      alu_op = 4'($urandom_range(0, 13)); alu_src_imm = 1'($urandom);
      shamt = 5'($urandom); id_res = $urandom;
      use_id_res = ($urandom_range(0, 7) == 0);
      t = $urandom_range(0, 5);
      md_op = (t == 0) ? MD_MFHI : (t == 1) ? MD_MFLO : MD_NONE;
      e0 = ref_pick(fwd_sel0, rdata0, fwd_data);
      e1 = ref_pick(fwd_sel1, rdata1, fwd_data);
      if (use_id_res) exp_res = id_res;
      else if (md_op == MD_MFHI) exp_res = hi_m;
      else if (md_op == MD_MFLO) exp_res = lo_m;
      else exp_res = ref_alu(alu_op, e0, alu_src_imm ? imm32 : e1, shamt);
      #1;
      t = tnew_in;
      chk("rnd_tnew_ex", tnew_ex, (t > 0) ? t - 1 : 0);
      if (in_valid && !flush) chk("rnd_waddr_ex", waddr_ex, waddr_in);
      tick();
      chk("rnd_alu_out", alu_out_o, exp_res);
      chk("rnd_dm_wdata", dm_wdata_o, e1);
      chk("rnd_pc", pc_o, pc_in);
      chk("rnd_valid", valid_o, in_valid && !flush);
      chk("rnd_waddr", waddr_o, (in_valid && !flush) ? waddr_in : 5'd0);
      chk("rnd_tnew", tnew_o, (in_valid && !flush) ? ((t > 0) ? t - 1 : 0) : 0);
    end

    for (int i = 0; i < 12; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 9);
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 1;
      run_md($sformatf("rnd_md[%0d]", i), rop, ra, rb);
    end

    idle();
    in_valid = 1; md_op = MD_DIV; rdata0 = 100; rdata1 = 7;
    tick();
    idle();
    tick();
    tick();
    tick();
    reset = 1;
    tick();
    chk("rst_mid_busy", md_busy, 0);
    chk("rst_mid_pc", pc_o, 32'h0000_3000);
    chk("rst_mid_valid", valid_o, 0);
    reset = 0;
    hi_m = 0; lo_m = 0;
    read_hilo("rst_mid_hilo");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_md_stage.md
Name: ex_md_stage

Overview:
- Parametrised next-generation execute stage.
- Sits between the ID/EX and EX/Mem pipeline boundaries.
- Selects forwarded operands from NUM_FWD bypass sources and evaluates the ALU.
- Adds a multi-cycle multiply/divide unit with HI/LO registers; its busy flag lets the hazard unit stall MD-class instructions in ID.
- Registers results into the EX/Mem pipeline register with a valid bit, so bubbles and flushes are explicit.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, GPR address width.
- NUM_FWD, 2, number of forwarding sources (index 1..NUM_FWD; 0 = ID/EX register value).
- T_W, 3, Tnew counter width.
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  load a bubble into EX/Mem this cycle.
- in_valid  in  1  ID/EX slot holds a real instruction.
- pc_in  in  DATA_W  instruction PC.
- waddr_in  in  REG_AW  GPR write address (0 = none).
- tnew_in  in  T_W  Tnew from ID.
- rdata0, rdata1  in  DATA_W  ID/EX operand values.
- imm32  in  DATA_W  extended immediate.
- shamt  in  5  shift amount.
- alu_op  in  4  ALU function code (shared package).
- alu_src_imm  in  1  In1 takes imm32.
- md_op  in  4  MD function code (shared package).
- id_res  in  DATA_W  result computed in ID (lui/jal link).
- use_id_res  in  1  result = id_res.
- fwd_data  in  NUM_FWD*DATA_W  bypass values; source k occupies bits [k*DATA_W-1 -: DATA_W].
- fwd_sel0, fwd_sel1  in  $clog2(NUM_FWD+1)  operand source select.
- md_busy  out  1  MD unit is busy or starting (combinational).
- waddr_ex  out  REG_AW  current EX write address (combinational, to hazard unit).
- tnew_ex  out  T_W  saturating tnew_in-1 (combinational).
- valid_o  out  1  registered EX/Mem valid.
- pc_o, alu_out_o, dm_wdata_o  out  DATA_W  registered.
- waddr_o  out  REG_AW  registered.
- tnew_o  out  T_W  registered.

Behaviour:
- Operand selection:
  - sel=0 takes rdata.
  - sel=k (1..NUM_FWD) takes source k.
  - sel>NUM_FWD drives 32'h1234_ABCD, the error marker.
- In1 = alu_src_imm ? imm32 : forwarded op1.
- dm_wdata_o always captures forwarded op1, never imm32.
- ALU ops: add, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav.
  - Variable shifts use op0[4:0]; fixed shifts use shamt.
  - Arithmetic wraps modulo 2^DATA_W; there is no overflow trap.
- Result priority: use_id_res, then mfhi/mflo (HI/LO), then the ALU.
- tnew_ex = (tnew_in>0) ? tnew_in-1 : 0.
- EX/Mem register:
  - Loads every cycle; there is no stall input.
  - If flush or !in_valid: valid_o=0, waddr_o=0, tnew_o=0; other fields still load.
- MD FSM, states IDLE and BUSY, with a count register:
  - IDLE→BUSY when in_valid && !flush && md_op∈{mult,multu,div,divu}. Operands are latched and count is loaded with MULT_CYCLES-1 or DIV_CYCLES-1.
  - In BUSY, count decrements each cycle. At count==0, HI/LO are written and the FSM returns to IDLE the same edge.
  - HI/LO therefore become visible MULT_CYCLES or DIV_CYCLES cycles after the start edge.
  - mult: {HI,LO} = signed product. multu: {HI,LO} = unsigned product.
  - div: LO = quotient, HI = remainder, both truncated toward zero, remainder taking the dividend's sign. divu: the same, unsigned.
  - Division by zero: the FSM still runs the full latency; HI/LO are left unchanged.
- mthi/mtlo write HI/LO at the next edge when valid and not flushed. They are legal only while IDLE; the hazard unit guarantees this.
- md_busy = (state==BUSY) || (start condition this cycle).
- flush does not abort an operation already in BUSY. An instruction that has left EX is committed.
- Reset (mid-operation included) forces:
  - State IDLE, count 0, HI=LO=0.
  - valid_o=0, pc_o=RESET_PC.
  - alu_out_o, dm_wdata_o, waddr_o, tnew_o all 0.

Optional Feature:
- EX_MADD_EN adds md_op codes madd, maddu, msub, msubu.
  - These take MULT_CYCLES and set {HI,LO} = {HI,LO} ± product, modulo 2^(2*DATA_W).
- Without the macro, these codes behave as md_op none.

Decomposition:
- Shared package ex_pkg holds: ALU_* and MD_* op encodings, FWD_ERR=32'h1234_ABCD, and MD state encodings.
- One sub-module, md_unit, contains the FSM, counter, HI/LO registers and the arithmetic.
- ALU and forwarding logic stay inline in ex_md_stage.

Test Plan:
- Forwarding: rdata0=5, fwd source 2=7, fwd_sel0=2, alu_op=add, imm32=3, alu_src_imm=1 → alu_out_o=10 next edge. fwd_sel0=3 (NUM_FWD=2) → op0=32'h1234_ABCD.
- mult: op0=-3, op1=4 → md_busy high for 5 cycles; mflo issued after busy drops returns 32'hFFFF_FFF4, mfhi returns 32'hFFFF_FFFF.
- div/divu:
  - div: op0=-7, op1=2 → LO=-3, HI=-1 after 10 cycles.
  - divu: op1=0 → HI/LO hold prior values; busy still lasts 10 cycles.
- Bubbles:
  - flush=1 with in_valid=1, waddr_in=8 → valid_o=0, waddr_o=0.
  - flush raised during BUSY → the MD operation still completes.
- Reset mid-operation: reset asserted 3 cycles into a div → next edge md_busy=0, HI=LO=0, pc_o=32'h0000_3000, valid_o=0.
- Tnew: tnew_in=0 → tnew_ex=0; tnew_in=2 → tnew_ex=1, tnew_o=1.
